// File: rtl/udp_tx_mux_engine_pkg.sv
// Shared types and constants for the multi-channel UDP transmitter.
// Holds FSM encoding, header sizing and last-word byte-enable codes.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PAY
  } state_e;

  localparam int          UDP_HDR_BYTES   = 8;
  localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd65527;

  localparam logic [1:0] BE_4 = 2'b00;
  localparam logic [1:0] BE_1 = 2'b01;
  localparam logic [1:0] BE_2 = 2'b10;
  localparam logic [1:0] BE_3 = 2'b11;

  function automatic logic [1:0] be_of(
    input logic [1:0] tail
  );
    logic [1:0] be;
    be = BE_4;
    unique case (tail)
      2'd0: be = BE_4;
      2'd1: be = BE_1;
      2'd2: be = BE_2;
      2'd3: be = BE_3;
      default: be = BE_4;
    endcase
    return be;
  endfunction

  // Payload is at most 65527 bytes, so ceil(len/4) fits 14 bits.
  function automatic logic [13:0] words_of(
    input logic [15:0] len
  );
    logic [16:0] t;
    t = {1'b0, len} + 17'd3;
    return t[15:2];
  endfunction

endpackage

// File: rtl/udp_tx_mux_engine_if.sv
// Output word stream of the UDP transmitter towards the IPv4 layer.
// Master drives the word and sideband; slave returns tx_ready.
interface udp_tx_mux_engine_if #(
  parameter int CH_W = 2
) ();

  logic [31:0]     tx_data;
  logic [1:0]      tx_be;
  logic            tx_valid;
  logic            tx_ready;
  logic            tx_last;
  logic [CH_W-1:0] tx_ch;

  modport master (
    output tx_data,
    output tx_be,
    output tx_valid,
    output tx_last,
    output tx_ch,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_be,
    input  tx_valid,
    input  tx_last,
    input  tx_ch,
    output tx_ready
  );

endinterface

// File: rtl/udp_tx_mux_engine_rr_arb.sv
// Round-robin arbiter: grants the first requester after ptr_i.
// Grants nothing unless advance_i is high.
module udp_tx_rr_arb #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  input  logic            advance_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] gnt_idx_o,
  output logic            any_o
);

  logic [CH_W-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CH_W'((int'(ptr_i) + k) % N_CH);
      if (advance_i && !any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/udp_tx_mux_engine.sv
// N_CH-channel UDP transmitter, one datagram per round-robin grant.
// Define UDP_TX_CHKSUM_EN to send the supplied checksum instead of 0.
module udp_tx_mux_engine
  import udp_tx_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH*16-1:0] ch_src_port,
  input  logic [N_CH*16-1:0] ch_dst_port,
  input  logic [N_CH*16-1:0] ch_len,
  input  logic [N_CH*16-1:0] ch_chksum,
  input  logic [N_CH*32-1:0] ch_data,
  output logic [N_CH-1:0]    ch_data_rd,
  output logic [N_CH-1:0]    ch_busy,
  output logic [N_CH-1:0]    ch_err,
  udp_tx_mux_engine_if.master tx
);

  state_e          state_q;
  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] g_q;
  logic [N_CH-1:0] busy_q;
  logic [N_CH-1:0] err_q;
  logic [31:0]     hdr_q;
  logic [31:0]     w1_q;
  logic [1:0]      tail_q;
  logic            zero_q;
  logic [13:0]     cnt_q;
  logic            valid_q;

  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gidx;
  logic            any;

  logic [15:0] src_g;
  logic [15:0] dst_g;
  logic [15:0] len_g;
  logic [15:0] ulen_d;
  logic [15:0] chk_d;
  logic [13:0] cnt_d;
  logic        xfer;
  logic        pay_last;

  udp_tx_rr_arb #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req_i     (ch_req),
    .ptr_i     (ptr_q),
    .advance_i (state_q == S_IDLE),
    .gnt_o     (gnt),
    .gnt_idx_o (gidx),
    .any_o     (any)
  );

  assign src_g  = ch_src_port[{gidx, 4'h0} +: 16];
  assign dst_g  = ch_dst_port[{gidx, 4'h0} +: 16];
  assign len_g  = ch_len[{gidx, 4'h0} +: 16];
  assign ulen_d = len_g + 16'(UDP_HDR_BYTES);
  assign cnt_d  = words_of(len_g);

`ifdef UDP_TX_CHKSUM_EN
  logic [15:0] chk_g;
  assign chk_g = ch_chksum[{gidx, 4'h0} +: 16];
  // Zero means "no checksum" on the wire, so a real 0 goes out as all-ones.
  assign chk_d = (chk_g == 16'h0000) ? 16'hFFFF : chk_g;
`else
  logic unused_chk;
  assign unused_chk = ^ch_chksum;
  assign chk_d      = 16'h0000;
`endif

  assign xfer     = valid_q & tx.tx_ready;
  assign pay_last = (state_q == S_PAY) && (cnt_q == 14'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      busy_q  <= '0;
      err_q   <= '0;
      hdr_q   <= '0;
      w1_q    <= '0;
      tail_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      err_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (any) begin
            ptr_q <= gidx;
            if (len_g > UDP_MAX_PAYLOAD) begin
              err_q <= gnt;
            end else begin
              g_q     <= gidx;
              busy_q  <= gnt;
              valid_q <= 1'b1;
              hdr_q   <= {src_g, dst_g};
              w1_q    <= {ulen_d, chk_d};
              tail_q  <= len_g[1:0];
              zero_q  <= (len_g == 16'd0);
              cnt_q   <= cnt_d;
              state_q <= S_HDR0;
            end
          end
        end
        S_HDR0: begin
          if (xfer) begin
            hdr_q   <= w1_q;
            state_q <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer) begin
            if (zero_q) begin
              valid_q <= 1'b0;
              busy_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (xfer) begin
            cnt_q <= cnt_q - 14'd1;
            if (cnt_q == 14'd1) begin
              valid_q <= 1'b0;
              busy_q  <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Payload words pass straight through from the show-ahead source.
  assign tx.tx_data  = (state_q == S_PAY) ?
                       ch_data[{g_q, 5'h00} +: 32] : hdr_q;
  assign tx.tx_be    = pay_last ? be_of(tail_q) : BE_4;
  assign tx.tx_last  = pay_last ||
                       ((state_q == S_HDR1) && zero_q);
  assign tx.tx_valid = valid_q;
  assign tx.tx_ch    = g_q;

  assign ch_data_rd = ((state_q == S_PAY) && tx.tx_ready) ?
                      busy_q : '0;
  assign ch_busy    = busy_q;
  assign ch_err     = err_q;

endmodule
